// File: rtl/ast_ctrl_pkg.sv
// Shared state encoding, widths and the saturating-increment helpers for the
// AST threshold controller.
package ast_ctrl_pkg;

   localparam int T_W   = 8;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVE,
      S_DRAIN,
      S_UPDATE,
      S_SKIP
   } ctrl_state_e;

   function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ast_thresh_ctrl_if.sv
// Register-file and detector-side signals of the threshold controller.
// slave: the controller itself; master: whatever drives the frame/config side.
interface ast_thresh_ctrl_if;
   import ast_ctrl_pkg::*;

   logic             run;
   logic             auto_en;
   logic [T_W-1:0]   t_manual;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] hyst;
   logic             fv;
   logic             qv;
   logic [T_W-1:0]   t;
   logic             en;
   logic [CNT_W-1:0] last_count;
   logic             upd;
   logic [CNT_W-1:0] frame_cnt;
   logic [7:0]       overrun_cnt;

   modport master (
      output run, auto_en, t_manual, target, hyst, fv, qv,
      input  t, en, last_count, upd, frame_cnt, overrun_cnt
   );

   modport slave (
      input  run, auto_en, t_manual, target, hyst, fv, qv,
      output t, en, last_count, upd, frame_cnt, overrun_cnt
   );

endinterface

// File: rtl/ast_thresh_step.sv
// Combinational auto-threshold step: moves t toward the target corner count,
// coarse when far off, fine when near, clamped to [T_MIN, T_MAX] without wrap.
module ast_thresh_step
   import ast_ctrl_pkg::*;
#(
   parameter logic [T_W-1:0] T_MIN       = 8'd4,
   parameter logic [T_W-1:0] T_MAX       = 8'd120,
   parameter logic [T_W-1:0] STEP_FINE   = 8'd1,
   parameter logic [T_W-1:0] STEP_COARSE = 8'd4
) (
   input  logic [T_W-1:0]   t_i,
   input  logic [CNT_W-1:0] n_i,
   input  logic [CNT_W-1:0] target_i,
   input  logic [CNT_W-1:0] hyst_i,
   output logic [T_W-1:0]   t_o
);

   logic [CNT_W:0] n17;
   logic [CNT_W:0] hi;
   logic [CNT_W:0] lo;
   logic [CNT_W:0] two_t;
   logic [CNT_W:0] half_t;
   logic [T_W:0]   step9;
   logic [T_W:0]   up9;
   logic [T_W:0]   dn9;

   always_comb begin
      n17    = {1'b0, n_i};
      hi     = {1'b0, target_i} + {1'b0, hyst_i};
      lo     = (target_i > hyst_i) ? {1'b0, target_i - hyst_i} : '0;
      two_t  = {target_i, 1'b0};
      half_t = {2'b00, target_i[CNT_W-1:1]};
      step9  = ((n17 >= two_t) || (n17 < half_t)) ? {1'b0, STEP_COARSE}
                                                   : {1'b0, STEP_FINE};
      up9    = {1'b0, t_i} + step9;
      // Floor at zero so the T_MIN clamp below sees the true (non-wrapped) value
      dn9    = ({1'b0, t_i} > step9) ? ({1'b0, t_i} - step9) : '0;

      t_o = t_i;
      if (n17 > hi) begin
         t_o = (up9 > {1'b0, T_MAX}) ? T_MAX : up9[T_W-1:0];
      end else if (n17 < lo) begin
         t_o = (dn9 < {1'b0, T_MIN}) ? T_MIN : dn9[T_W-1:0];
      end
   end

endmodule

// File: rtl/ast_thresh_ctrl.sv
// Frame-level AST controller: arms en on whole frames, counts qv through a drain
// window, refreshes t between frames. ASTC_FRAME_STATS_EN enables frame/overrun counters.
module ast_thresh_ctrl
   import ast_ctrl_pkg::*;
#(
   parameter logic [T_W-1:0] T_INIT      = 8'd20,
   parameter logic [T_W-1:0] T_MIN       = 8'd4,
   parameter logic [T_W-1:0] T_MAX       = 8'd120,
   parameter logic [T_W-1:0] STEP_FINE   = 8'd1,
   parameter logic [T_W-1:0] STEP_COARSE = 8'd4,
   parameter int             DRAIN       = 32
) (
   input  logic             c,
   input  logic             rst,
   ast_thresh_ctrl_if.slave bus
);

   localparam int            DW         = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN - 1);

   ctrl_state_e      state_q, state_d;
   logic             en_q, en_d;
   logic [T_W-1:0]   t_q, t_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] last_count_q, last_count_d;
   logic             upd_q, upd_d;
   logic             fv_d1_q;
   logic             fs, fe;
   logic [T_W-1:0]   t_step;

   assign fs = bus.fv & ~fv_d1_q;
   assign fe = ~bus.fv & fv_d1_q;

   ast_thresh_step #(
      .T_MIN      (T_MIN),
      .T_MAX      (T_MAX),
      .STEP_FINE  (STEP_FINE),
      .STEP_COARSE(STEP_COARSE)
   ) u_step (
      .t_i     (t_q),
      .n_i     (count_q),
      .target_i(bus.target),
      .hyst_i  (bus.hyst),
      .t_o     (t_step)
   );

   always_comb begin
      state_d      = state_q;
      en_d         = en_q;
      t_d          = t_q;
      count_d      = count_q;
      drain_d      = drain_q;
      ovr_d        = ovr_q;
      last_count_d = last_count_q;
      upd_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fs) begin
               if (bus.run) begin
                  state_d = S_ACTIVE;
                  en_d    = 1'b1;
                  count_d = '0;
                  ovr_d   = 1'b0;
                  if (!bus.auto_en) t_d = bus.t_manual;
               end else begin
                  state_d = S_SKIP;
               end
            end
         end
         S_ACTIVE: begin
            if (bus.qv) count_d = sat_inc16(count_q);
            if (fe) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         S_DRAIN: begin
            if (bus.qv) count_d = sat_inc16(count_q);
            // A new frame arriving mid-drain closes this one early and is skipped
            if (fs) begin
               state_d = S_UPDATE;
               en_d    = 1'b0;
               ovr_d   = 1'b1;
            end else if (drain_q == '0) begin
               state_d = S_UPDATE;
               en_d    = 1'b0;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         S_UPDATE: begin
            last_count_d = count_q;
            upd_d        = 1'b1;
            if (bus.auto_en) t_d = t_step;
            state_d = ovr_q ? S_SKIP : S_IDLE;
            ovr_d   = 1'b0;
         end
         S_SKIP: begin
            if (fe) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // fv_d1 keeps tracking fv through reset so a frame already in flight at
   // reset release is not mistaken for a frame start.
   always_ff @(posedge c) begin
      fv_d1_q <= bus.fv;
      if (rst) begin
         state_q      <= S_IDLE;
         en_q         <= 1'b0;
         t_q          <= T_INIT;
         count_q      <= '0;
         drain_q      <= '0;
         ovr_q        <= 1'b0;
         last_count_q <= '0;
         upd_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         t_q          <= t_d;
         count_q      <= count_d;
         drain_q      <= drain_d;
         ovr_q        <= ovr_d;
         last_count_q <= last_count_d;
         upd_q        <= upd_d;
      end
   end

`ifdef ASTC_FRAME_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q;
   logic [7:0]       overrun_cnt_q;

   always_ff @(posedge c) begin
      if (rst) begin
         frame_cnt_q   <= '0;
         overrun_cnt_q <= '0;
      end else if (state_q == S_UPDATE) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
         if (ovr_q) overrun_cnt_q <= sat_inc8(overrun_cnt_q);
      end
   end

   assign bus.frame_cnt   = frame_cnt_q;
   assign bus.overrun_cnt = overrun_cnt_q;
`else
   assign bus.frame_cnt   = '0;
   assign bus.overrun_cnt = '0;
`endif

   assign bus.t          = t_q;
   assign bus.en         = en_q;
   assign bus.last_count = last_count_q;
   assign bus.upd        = upd_q;

endmodule

// File: doc/ast_thresh_ctrl.md
Name: ast_thresh_ctrl

Overview:
- Per-camera frame-level controller for the AST corner detector.
- Arms the detector `en` on whole-frame boundaries only.
- Counts accepted corner words (`qv`) per frame, including a post-frame drain window.
- Between frames, steers the 8-bit threshold `t` toward a target corner count (auto mode), or applies a software threshold (manual mode). `t` never changes while a frame is in progress.
- Sits between the register file and the detector, in the pixel clock domain.

Parameters:
- T_INIT, 20: threshold after reset.
- T_MIN, 4: lower clamp for auto mode.
- T_MAX, 120: upper clamp for auto mode.
- STEP_FINE, 1: step size when the count is near target.
- STEP_COARSE, 4: step size when the count is far from target.
- DRAIN, 32: cycles after fv falls during which `qv` is still counted (detector pipeline flush).

Ports:
- c  in  1  pixel clock.
- rst  in  1  synchronous reset, active high.
- run  in  1  software enable; sampled only at frame start.
- auto_en  in  1  1 = adaptive threshold, 0 = manual.
- t_manual  in  8  manual threshold.
- target  in  16  desired corners per frame.
- hyst  in  16  dead band around target.
- fv  in  1  frame valid (same signal that feeds the detector).
- qv  in  1  detector corner-word valid.
- t  out  8  threshold to detector.
- en  out  1  detector write enable.
- last_count  out  16  corner count of the last closed frame.
- upd  out  1  one-cycle pulse when last_count/t are refreshed.
- frame_cnt  out  16  frames processed (optional feature).
- overrun_cnt  out  8  frames skipped due to overrun (optional feature).

Behaviour:
- Reset values: t=T_INIT, en=0, last_count=0, upd=0, frame_cnt=0, overrun_cnt=0, count=0, state IDLE.
- Edge detection: fv_d1 is a registered copy of fv. fs = fv & ~fv_d1; fe = ~fv & fv_d1.
- IDLE:
  - On fs with run=1: go to ACTIVE, en<=1 next cycle, count<=0.
  - If auto_en=0, t<=t_manual on the same edge.
  - On fs with run=0: go to SKIP, en stays 0.
- ACTIVE:
  - Each cycle with qv=1: count+1, saturating at 16'hFFFF.
  - On fe: go to DRAIN, en stays 1, drain counter loaded with DRAIN-1.
- DRAIN:
  - Keep counting qv.
  - When the drain counter reaches 0: go to UPDATE, en<=0.
  - fs during DRAIN is an overrun: go to UPDATE with ovr flag set, en<=0. The current-cycle qv is still counted.
- UPDATE (exactly one cycle):
  - last_count<=count, upd=1, frame_cnt+1.
  - If auto_en=1, t is updated per the rule below.
  - Next state is IDLE, except when ovr is set: then go to SKIP and overrun_cnt+1 (saturating at 8'hFF).
- SKIP: wait for fe, then IDLE. en=0 throughout; the frame is not counted.
- Auto rule (17-bit unsigned arithmetic; N=count, T=target):
  - hi = T+hyst.
  - lo = T-hyst, floored at 0.
  - Step is STEP_COARSE if N >= 2T or N < T>>1; otherwise STEP_FINE.
  - N > hi: t<=min(t+step, T_MAX).
  - N < lo: t<=max(t-step, T_MIN).
  - Otherwise t holds.
  - Compute in 9 bits before clamping; no wrap.
- Mode changes:
  - auto_en 0->1: adaptation continues from the current t.
  - auto_en 1->0: t_manual takes effect at the next armed fs.
  - auto_en is sampled in UPDATE.
- target=0: any N>0 raises t. t never lowers below T_MIN.
- run deasserted mid-frame: no effect until the next frame start.
- rst asserted in any state: return to reset values next cycle. en drops immediately, i.e. the registered en is 0 after the reset edge.

Optional Feature:
- ASTC_FRAME_STATS_EN defined: frame_cnt and overrun_cnt are live counters as described above.
- Not defined: both outputs are tied to 0, their counters are not instantiated, and overruns still force SKIP.

Decomposition:
- Shared package ast_ctrl_pkg contains:
  - state encoding: IDLE, ACTIVE, DRAIN, UPDATE, SKIP;
  - width constants: T_W=8, CNT_W=16;
  - saturating-increment helper.
- One sub-module: ast_thresh_step. It is combinational: (t, N, target, hyst, T_MIN/T_MAX/steps) -> next t. It is used in UPDATE and unit-tested separately.

Test Plan:
- Reset, then run=1, auto_en=0, t_manual=35, one frame with 100 qv pulses and 10 more within 32 cycles after fe -> t=35, en high from fs+1 to fe+32, upd pulse with last_count=110.
- auto_en=1, t=20, target=100, hyst=10, frame with 300 corners -> t=24 (coarse step). Next frame with 105 corners -> t stays 24. Next frame with 80 corners -> t=23.
- t=118, T_MAX=120, repeated frames with 5000 corners -> t=120 and holds. Repeated frames with 0 corners down to T_MIN=4 -> t=4, never below.
- qv held high for 70000 cycles in one frame -> last_count=16'hFFFF, no wrap.
- fv rises 10 cycles after fe (inside DRAIN) -> UPDATE fires immediately, that frame is SKIPped with en=0, overrun_cnt=1. The following frame is armed normally.
- rst asserted mid-ACTIVE after 50 corners -> next cycle en=0, t=T_INIT, last_count=0. A new fs re-arms cleanly.
